tdc_code_accum: RTL and testbench

TDC_CODE_ACCUM -- requirements
Module: tdc_code_accum

---
 rtl/tdc_code_accum.sv | 161 ++++++++++++++++
 tb/tb_tdc_code_accum.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_code_accum.sv
// tdc_code_accum: turns thermometer snapshots from a TDC delay line into
// sample codes (popcount) and accumulates 2**LOG2_SAMPLES of them into a
// measurement: sum, truncated average, min, max and a bubble count.
module tdc_code_accum #(
    parameter int N_DELAY      = 32,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_DELAY-1:0]        therm_in,
    input  logic                      therm_valid,
    input  logic                      meas_start,
    output logic                      busy,
    output logic                      done,
    output logic [6+LOG2_SAMPLES-1:0] sum_code,
    output logic [5:0]                avg_code,
    output logic [5:0]                min_code,
    output logic [5:0]                max_code,
    output logic [3:0]                bubble_cnt
);

    localparam int SW = 6 + LOG2_SAMPLES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counting ones is inherently bubble-tolerant: a stray zero below the
    // edge and a stray one above it cancel out instead of corrupting the code.
    function automatic logic [5:0] popcount_f(input logic [N_DELAY-1:0] v);
        logic [5:0] acc;
        acc = 6'd0;
        for (int i = 0; i < N_DELAY; i++) begin
            acc = acc + {5'd0, v[i]};
        end
        return acc;
    endfunction

    // A clean thermometer is 2**k-1, so adding one clears every set bit.
    // All-ones wraps to zero and is therefore also clean.
    function automatic logic is_bubble_f(input logic [N_DELAY-1:0] v);
        logic [N_DELAY-1:0] inc;
        inc = v + N_DELAY'(1);
        return ((v & inc) != {N_DELAY{1'b0}});
    endfunction

    state_t                    state_r;
    logic [SW-1:0]             sum_acc_r;
    logic [5:0]                min_acc_r;
    logic [5:0]                max_acc_r;
    logic [3:0]                bub_acc_r;
    logic [LOG2_SAMPLES-1:0]   cnt_r;

    logic [5:0]                code_s;
    logic                      bubble_s;
    logic                      accept_s;
    logic                      last_s;
    logic [SW-1:0]             sum_nx_s;
    logic [5:0]                min_nx_s;
    logic [5:0]                max_nx_s;
    logic [3:0]                bub_nx_s;

    // Per-sample code and the accumulator values after folding it in.
    always_comb begin
        code_s   = popcount_f(therm_in);
        bubble_s = is_bubble_f(therm_in);
        accept_s = (state_r == ST_RUN) && therm_valid;
        last_s   = (cnt_r == {LOG2_SAMPLES{1'b1}});
        sum_nx_s = sum_acc_r + SW'(code_s);
        if (code_s < min_acc_r) begin
            min_nx_s = code_s;
        end else begin
            min_nx_s = min_acc_r;
        end
        if (code_s > max_acc_r) begin
            max_nx_s = code_s;
        end else begin
            max_nx_s = max_acc_r;
        end
        if (bubble_s && (bub_acc_r != 4'd15)) begin
            bub_nx_s = bub_acc_r + 4'd1;
        end else begin
            bub_nx_s = bub_acc_r;
        end
    end

    // Measurement FSM with working accumulators and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            sum_acc_r  <= {SW{1'b0}};
            min_acc_r  <= 6'd0;
            max_acc_r  <= 6'd0;
            bub_acc_r  <= 4'd0;
            cnt_r      <= {LOG2_SAMPLES{1'b0}};
            sum_code   <= {SW{1'b0}};
            avg_code   <= 6'd0;
            min_code   <= 6'd0;
            max_code   <= 6'd0;
            bubble_cnt <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (meas_start) begin
                        state_r   <= ST_RUN;
                        busy      <= 1'b1;
                        sum_acc_r <= {SW{1'b0}};
                        min_acc_r <= 6'd63;
                        max_acc_r <= 6'd0;
                        bub_acc_r <= 4'd0;
                        cnt_r     <= {LOG2_SAMPLES{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        sum_acc_r <= sum_nx_s;
                        min_acc_r <= min_nx_s;
                        max_acc_r <= max_nx_s;
                        bub_acc_r <= bub_nx_s;
                        cnt_r     <= cnt_r + LOG2_SAMPLES'(1);
                        if (last_s) begin
                            // Results are loaded from the post-update values so
                            // the final sample is included on the DONE entry edge.
                            state_r    <= ST_DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            sum_code   <= sum_nx_s;
                            avg_code   <= sum_nx_s[LOG2_SAMPLES +: 6];
                            min_code   <= min_nx_s;
                            max_code   <= max_nx_s;
                            bubble_cnt <= bub_nx_s;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_code_accum.sv
// Directed testbench for tdc_code_accum at default parameters.
module tb_tdc_code_accum;

    logic        clk;
    logic        rst_n;
    logic [31:0] therm_in;
    logic        therm_valid;
    logic        meas_start;
    logic        busy;
    logic        done;
    logic [9:0]  sum_code;
    logic [5:0]  avg_code;
    logic [5:0]  min_code;
    logic [5:0]  max_code;
    logic [3:0]  bubble_cnt;

    int checks;
    int failures;

    tdc_code_accum #(.N_DELAY(32), .LOG2_SAMPLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .therm_in   (therm_in),
        .therm_valid(therm_valid),
        .meas_start (meas_start),
        .busy       (busy),
        .done       (done),
        .sum_code   (sum_code),
        .avg_code   (avg_code),
        .min_code   (min_code),
        .max_code   (max_code),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse meas_start, then feed 16 samples (optionally with one idle cycle
    // between valids). Returns edges from the start cycle and done after the last.
    task automatic drive_meas(input logic [31:0] s [16], input bit gaps,
                              output int edges, output logic done_last);
        edges = 0;
        meas_start = 1'b1; therm_valid = 1'b0;
        step(); edges++;
        meas_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (gaps && i > 0) begin
                therm_valid = 1'b0;
                step(); edges++;
            end
            therm_in = s[i]; therm_valid = 1'b1;
            step(); edges++;
        end
        therm_valid = 1'b0;
        done_last = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; meas_start = 1'b0; therm_valid = 1'b0; therm_in = 32'd0;
        step(); step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum_code !== 10'd0 || avg_code !== 6'd0 || min_code !== 6'd0 || max_code !== 6'd0 || bubble_cnt !== 4'd0) begin
            failures++; $display("FAIL reset_outputs got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0", sum_code, avg_code, min_code, max_code, bubble_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_constant();
        logic [31:0] s [16];
        int          edges;
        logic        dl;
        for (int i = 0; i < 16; i++) s[i] = 32'h0000_00FF;
        drive_meas(s, 1'b0, edges, dl);
        checks++; if (dl !== 1'b1) begin failures++; $display("FAIL const_done got=%b exp=1", dl); end
        checks++; if (edges !== 17) begin failures++; $display("FAIL const_latency got_cycle=%0d exp_cycle=18", edges + 1); end
        checks++; if (sum_code !== 10'd128) begin failures++; $display("FAIL const_sum got=%0d exp=128", sum_code); end
        checks++; if (avg_code !== 6'd8) begin failures++; $display("FAIL const_avg got=%0d exp=8", avg_code); end
        checks++; if (min_code !== 6'd8 || max_code !== 6'd8) begin failures++; $display("FAIL const_minmax got=%0d/%0d exp=8/8", min_code, max_code); end
        checks++; if (bubble_cnt !== 4'd0) begin failures++; $display("FAIL const_bubble got=%0d exp=0", bubble_cnt); end
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL const_done_width got=%b/%b exp=0/0", done, busy); end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        meas_start = 1'b1; step(); meas_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            therm_in = 32'hFFFF_FFFF; therm_valid = 1'b1; step();
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrun_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrun_reset_ctl got=%b/%b exp=0/0", busy, done); end
        checks++; if (sum_code !== 10'd0 || avg_code !== 6'd0 || min_code !== 6'd0 || max_code !== 6'd0 || bubble_cnt !== 4'd0) begin
            failures++; $display("FAIL midrun_reset_out got=%0d/%0d/%0d/%0d/%0d exp=0/0/0/0/0", sum_code, avg_code, min_code, max_code, bubble_cnt);
        end
        step();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            therm_valid = i[0];
            step();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        therm_valid = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL midrun_no_restart got=%0d bad_cycles exp=0", bad); end
    endtask

    task automatic test_ramp_gaps();
        logic [31:0] s [16];
        int          edges;
        logic        dl;
        for (int i = 0; i < 16; i++) s[i] = (32'd1 << i) - 32'd1;
        drive_meas(s, 1'b1, edges, dl);
        checks++; if (dl !== 1'b1) begin failures++; $display("FAIL ramp_done got=%b exp=1", dl); end
        checks++; if (edges !== 32) begin failures++; $display("FAIL ramp_latency got=%0d exp=32", edges); end
        checks++; if (sum_code !== 10'd120) begin failures++; $display("FAIL ramp_sum got=%0d exp=120", sum_code); end
        checks++; if (avg_code !== 6'd7) begin failures++; $display("FAIL ramp_avg got=%0d exp=7", avg_code); end
        checks++; if (min_code !== 6'd0 || max_code !== 6'd15) begin failures++; $display("FAIL ramp_minmax got=%0d/%0d exp=0/15", min_code, max_code); end
        checks++; if (bubble_cnt !== 4'd0) begin failures++; $display("FAIL ramp_bubble got=%0d exp=0", bubble_cnt); end
        step();
    endtask

    task automatic test_bubbles();
        logic [31:0] s [16];
        int          edges;
        logic        dl;
        for (int i = 0; i < 16; i++) s[i] = (i < 8) ? 32'h0000_00F7 : 32'hFFFF_FFFF;
        drive_meas(s, 1'b0, edges, dl);
        checks++; if (dl !== 1'b1) begin failures++; $display("FAIL bub_done got=%b exp=1", dl); end
        checks++; if (sum_code !== 10'd312) begin failures++; $display("FAIL bub_sum got=%0d exp=312", sum_code); end
        checks++; if (avg_code !== 6'd19) begin failures++; $display("FAIL bub_avg got=%0d exp=19", avg_code); end
        checks++; if (min_code !== 6'd7 || max_code !== 6'd32) begin failures++; $display("FAIL bub_minmax got=%0d/%0d exp=7/32", min_code, max_code); end
        checks++; if (bubble_cnt !== 4'd8) begin failures++; $display("FAIL bub_count got=%0d exp=8", bubble_cnt); end
        step();
        // 16 bubbled samples of code 1: bubble count saturates at 15.
        for (int i = 0; i < 16; i++) s[i] = 32'h0000_0002;
        drive_meas(s, 1'b0, edges, dl);
        checks++; if (bubble_cnt !== 4'd15) begin failures++; $display("FAIL bub_saturate got=%0d exp=15", bubble_cnt); end
        checks++; if (sum_code !== 10'd16 || avg_code !== 6'd1 || min_code !== 6'd1 || max_code !== 6'd1) begin
            failures++; $display("FAIL bub_sat_vals got=%0d/%0d/%0d/%0d exp=16/1/1/1", sum_code, avg_code, min_code, max_code);
        end
        step();
    endtask

    task automatic test_ignored_controls();
        int bad;
        int n;
        bad = 0;
        therm_in = 32'hFFFF_FFFF; therm_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (busy !== 1'b0) bad++;
        end
        therm_valid = 1'b0;
        meas_start = 1'b1; step(); meas_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            therm_in = 32'h0000_00FF; therm_valid = 1'b1;
            meas_start = (i == 5 || i == 6);
            step();
            if (i < 15 && done !== 1'b0) bad++;
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", done); end
        // DONE cycle: start and a big sample are both presented and must be ignored.
        meas_start = 1'b1; therm_in = 32'hFFFF_FFFF; therm_valid = 1'b1;
        step();
        meas_start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_done_start got=%b exp=0", busy); end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy !== 1'b0 || done !== 1'b0) n++;
        end
        therm_valid = 1'b0;
        checks++; if (bad !== 0 || n !== 0) begin failures++; $display("FAIL ign_ctrl got=%0d/%0d bad_cycles exp=0/0", bad, n); end
        checks++; if (sum_code !== 10'd128 || avg_code !== 6'd8 || min_code !== 6'd8 || max_code !== 6'd8 || bubble_cnt !== 4'd0) begin
            failures++; $display("FAIL ign_results got=%0d/%0d/%0d/%0d/%0d exp=128/8/8/8/0", sum_code, avg_code, min_code, max_code, bubble_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        meas_start = 1'b1; therm_valid = 1'b1; therm_in = 32'h0000_FFFF;
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy1 got=%b exp=1", busy); end
        n = 0;
        while (done !== 1'b1 && n < 40) begin step(); n++; end
        checks++; if (n !== 16) begin failures++; $display("FAIL b2b_first_len got=%0d exp=16", n); end
        checks++; if (sum_code !== 10'd256 || avg_code !== 6'd16 || min_code !== 6'd16 || max_code !== 6'd16) begin
            failures++; $display("FAIL b2b_first got=%0d/%0d/%0d/%0d exp=256/16/16/16", sum_code, avg_code, min_code, max_code);
        end
        therm_in = 32'h0000_000F;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b/%b exp=0/0", busy, done); end
        step();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got=%b exp=1", busy); end
        for (int i = 0; i < 8; i++) step();
        checks++; if (sum_code !== 10'd256 || min_code !== 6'd16) begin failures++; $display("FAIL b2b_hold got=%0d/%0d exp=256/16", sum_code, min_code); end
        n = 0;
        while (done !== 1'b1 && n < 40) begin step(); n++; end
        checks++; if (n !== 8) begin failures++; $display("FAIL b2b_second_len got=%0d exp=8", n); end
        checks++; if (sum_code !== 10'd64 || avg_code !== 6'd4 || min_code !== 6'd4 || max_code !== 6'd4) begin
            failures++; $display("FAIL b2b_second got=%0d/%0d/%0d/%0d exp=64/4/4/4", sum_code, avg_code, min_code, max_code);
        end
        meas_start = 1'b0; therm_valid = 1'b0;
        step(); step();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_constant();
        test_reset_mid_run();
        test_ramp_gaps();
        test_bubbles();
        test_ignored_controls();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
